// File: rtl/arb_pkg.sv
// Shared definitions for the round-robin L2 arbiter and its neighbours:
// FSM state encoding and the bus_select codes derived from the cache count.
package arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    XFER  = 2'd2,
    ABORT = 2'd3
  } arb_state_t;

  // bus_select value that routes the shared bus to the L2.
  function automatic int sel_l2_code(input int n_cache);
    return n_cache;
  endfunction

  // bus_select value meaning nobody drives the bus.
  function automatic int sel_idle_code(input int n_cache);
    return n_cache + 1;
  endfunction

endpackage

// File: rtl/arbiter_rr_pick.sv
// Combinational round-robin picker: first set request bit searching upward
// from last+1, wrapping modulo N.
module rr_pick #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last,
  output logic             valid,
  output logic [IDX_W-1:0] winner
);

  always_comb begin
    int idx;
    valid  = 1'b0;
    winner = last;
    // Walk from farthest to nearest so the nearest requester is written last.
    for (int k = N; k >= 1; k--) begin
      idx = (int'(last) + k) % N;
      if (req[idx]) begin
        valid  = 1'b1;
        winner = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/arbiter_rr.sv
// Round-robin arbiter of N_CACHE L1 caches for the shared L2/bus path, with
// an optional per-phase watchdog that aborts a stuck handshake.
module arbiter_rr
  import arb_pkg::*;
#(
  parameter int N_CACHE     = 4,
  parameter int TIMEOUT_CYC = 0,
  parameter int SEL_W       = $clog2(N_CACHE + 2),
  parameter int CNT_W       = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [N_CACHE-1:0]         c_start,
  input  logic [N_CACHE-1:0]         c_done,
  input  logic                       L2_done,
  output logic [N_CACHE-1:0]         c_go,
  output logic                       L2_start,
  output logic [SEL_W-1:0]           bus_select,
  output logic [$clog2(N_CACHE)-1:0] grant_id,
  output logic                       busy,
  output logic                       err,
  output logic [$clog2(N_CACHE)-1:0] err_id
);

  localparam int IDX_W = $clog2(N_CACHE);
  localparam logic [SEL_W-1:0] SEL_IDLE = SEL_W'(sel_idle_code(N_CACHE));
  localparam logic [SEL_W-1:0] SEL_L2   = SEL_W'(sel_l2_code(N_CACHE));
  localparam logic [CNT_W-1:0] CNT_LIM  = CNT_W'(TIMEOUT_CYC);

  arb_state_t       state_reg, state_next;
  logic [IDX_W-1:0] grant_reg, grant_next;
  logic [IDX_W-1:0] err_id_reg, err_id_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [CNT_W-1:0] cnt_inc;
  logic             expire;
  logic             pick_valid;
  logic [IDX_W-1:0] pick_id;

  rr_pick #(
    .N     (N_CACHE),
    .IDX_W (IDX_W)
  ) u_pick (
    .req    (c_start),
    .last   (grant_reg),
    .valid  (pick_valid),
    .winner (pick_id)
  );

  // cnt_inc is the number of cycles spent in the phase including this one;
  // the phase expires at the end of its TIMEOUT_CYC-th cycle.
  assign cnt_inc = cnt_reg + CNT_W'(1);
  assign expire  = (TIMEOUT_CYC != 0) && (cnt_inc == CNT_LIM);

  always_comb begin
    state_next  = state_reg;
    grant_next  = grant_reg;
    err_id_next = err_id_reg;
    cnt_next    = cnt_reg;
    case (state_reg)
      IDLE: begin
        cnt_next = '0;
        if (pick_valid) begin
          state_next = REQ;
          grant_next = pick_id;
        end
      end
      REQ: begin
        if (L2_done) begin
          state_next = XFER;
          cnt_next   = '0;
        end else if (expire) begin
          state_next  = ABORT;
          err_id_next = grant_reg;
          cnt_next    = '0;
        end else begin
          cnt_next = (TIMEOUT_CYC == 0) ? '0 : cnt_inc;
        end
      end
      XFER: begin
        if (c_done[grant_reg]) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else if (expire) begin
          state_next  = ABORT;
          err_id_next = grant_reg;
          cnt_next    = '0;
        end else begin
          cnt_next = (TIMEOUT_CYC == 0) ? '0 : cnt_inc;
        end
      end
      ABORT: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= IDLE;
      grant_reg  <= IDX_W'(N_CACHE - 1);
      err_id_reg <= '0;
      cnt_reg    <= '0;
    end else begin
      state_reg  <= state_next;
      grant_reg  <= grant_next;
      err_id_reg <= err_id_next;
      cnt_reg    <= cnt_next;
    end
  end

  // Outputs decode registers only, so no input reaches an output in the same cycle.
  genvar gi;
  generate
    for (gi = 0; gi < N_CACHE; gi++) begin : g_go
      assign c_go[gi] = (state_reg == XFER) && (grant_reg == IDX_W'(gi));
    end
  endgenerate

  always_comb begin
    bus_select = SEL_IDLE;
    L2_start   = 1'b0;
    err        = 1'b0;
    case (state_reg)
      REQ: begin
        L2_start   = 1'b1;
        bus_select = SEL_W'(grant_reg);
      end
      XFER:    bus_select = SEL_L2;
      ABORT:   err = 1'b1;
      default: bus_select = SEL_IDLE;
    endcase
  end

  assign busy     = (state_reg != IDLE);
  assign grant_id = grant_reg;
  assign err_id   = err_id_reg;

endmodule

// File: tb/tb_arbiter_rr.sv
// Bench for arbiter_rr (N_CACHE=4, TIMEOUT_CYC=8): directed scenarios then
// random traffic, every cycle compared against a transaction-level model.
module tb_arbiter_rr;
  localparam int N  = 4;
  localparam int TO = 8;
  localparam int SW = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic [N-1:0]  c_start, c_done, c_go;
  logic          L2_done, L2_start, busy, err;
  logic [SW-1:0] bus_select;
  logic [1:0]    grant_id, err_id;

  int vectors = 0;
  int miscompares = 0;

  // Model: phase 0 idle, 1 waiting for L2, 2 data transfer, 3 abort cycle.
  int m_phase = 0;
  int m_gid   = N - 1;
  int m_eid   = 0;
  int m_spent = 0;
  int cyc_no  = 0;

  arbiter_rr #(.N_CACHE(N), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .reset(reset), .c_start(c_start), .c_done(c_done),
    .L2_done(L2_done), .c_go(c_go), .L2_start(L2_start),
    .bus_select(bus_select), .grant_id(grant_id), .busy(busy),
    .err(err), .err_id(err_id)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL cycle %0d %s: got %0d expected %0d", cyc_no, tag, got, exp);
    end
  endtask

  task automatic model_step(input int cs, input int l2d, input int cd, input int rst);
    if (rst != 0) begin
      m_phase = 0; m_gid = N - 1; m_eid = 0; m_spent = 0;
    end else begin
      case (m_phase)
        0: if (cs != 0) begin
          for (int k = 1; k <= N; k++) begin
            if (m_phase == 0 && ((cs >> ((m_gid + k) % N)) & 1) == 1) begin
              m_gid = (m_gid + k) % N;
              m_phase = 1;
              m_spent = 0;
            end
          end
        end
        1: begin
          m_spent++;
          if (l2d != 0) begin m_phase = 2; m_spent = 0; end
          else if (m_spent == TO) begin m_phase = 3; m_eid = m_gid; end
        end
        2: begin
          m_spent++;
          if (((cd >> m_gid) & 1) == 1) m_phase = 0;
          else if (m_spent == TO) begin m_phase = 3; m_eid = m_gid; end
        end
        default: m_phase = 0;
      endcase
    end
  endtask

  // Apply one cycle of inputs, advance the model, compare just after the edge.
  task automatic cycle(input int cs, input int l2d, input int cd, input int rst);
    c_start = N'(cs); L2_done = (l2d != 0); c_done = N'(cd); reset = (rst != 0);
    @(posedge clk);
    #1;
    cyc_no++;
    model_step(cs, l2d, cd, rst);
    check("c_go",       int'(c_go),       (m_phase == 2) ? (1 << m_gid) : 0);
    check("L2_start",   int'(L2_start),   (m_phase == 1) ? 1 : 0);
    check("bus_select", int'(bus_select), (m_phase == 1) ? m_gid : (m_phase == 2) ? N : N + 1);
    check("grant_id",   int'(grant_id),   m_gid);
    check("busy",       int'(busy),       (m_phase != 0) ? 1 : 0);
    check("err",        int'(err),        (m_phase == 3) ? 1 : 0);
    check("err_id",     int'(err_id),     m_eid);
  endtask

  initial begin
    int cs, l2_prob, cd;
    cycle(0, 0, 0, 1);
    cycle(0, 0, 0, 1);
    // single request from cache 2
    cycle('b0100, 0, 0, 0);
    cycle('b0100, 1, 0, 0);
    cycle(0, 0, 'b1011, 0);
    cycle(0, 0, 'b0100, 0);
    cycle(0, 0, 0, 0);
    // all requesting, 1-cycle answers: grants 3,0,1,2,3 after last=2
    for (int i = 0; i < 5; i++) begin
      cycle('b1111, 0, 0, 0);
      cycle('b1111, 1, 0, 0);
      cycle('b1111, 0, 'b1111, 0);
    end
    // priority rotation with last grant 1
    cycle(0, 0, 0, 1);
    cycle('b0010, 0, 0, 0); cycle(0, 1, 0, 0); cycle(0, 0, 'b0010, 0);
    for (int i = 0; i < 2; i++) begin
      cycle('b1001, 0, 0, 0); cycle('b1001, 1, 0, 0); cycle('b1001, 0, 'b1111, 0);
    end
    // watchdog in REQ with cache 1, then arbitration with 0011
    cycle(0, 0, 0, 1);
    cycle('b0010, 0, 0, 0);
    for (int i = 0; i < TO + 1; i++) cycle(0, 0, 0, 0);
    cycle('b0011, 0, 0, 0);
    cycle(0, 1, 0, 0); cycle(0, 0, 'b0001, 0);
    // completion arriving exactly on the expiry cycle
    cycle('b0100, 0, 0, 0);
    for (int i = 0; i < TO - 1; i++) cycle(0, 0, 0, 0);
    cycle(0, 1, 0, 0);
    // watchdog in XFER
    for (int i = 0; i < TO + 1; i++) cycle(0, 0, 0, 0);
    // reset in the middle of a transfer to cache 1
    cycle('b0010, 0, 0, 0); cycle(0, 1, 0, 0); cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 1);
    cycle(0, 0, 0, 0);
    // random traffic
    cs = 0; l2_prob = 2;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 3) == 0) cs = int'($urandom_range(0, 15));
      if ($urandom_range(0, 49) == 0) l2_prob = ($urandom_range(0, 1) == 0) ? 2 : 12;
      cd = ($urandom_range(0, l2_prob - 1) == 0) ? int'($urandom_range(0, 15)) : 0;
      cycle(cs, ($urandom_range(0, l2_prob - 1) == 0) ? 1 : 0, cd,
            ($urandom_range(0, 299) == 0) ? 1 : 0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
